irq_ctl: RTL
============

# irq_ctl

Memory-mapped interrupt controller that sits directly upstream of the 65C02 `cpu` block. It synchronises eight external interrupt sources and one NMI source, latches or follows them per source, masks them, and drives the CPU's `IRQ` and `NMI` inputs. A 4-byte register window on the CPU bus lets software enable sources, pick edge or level mode, acknowledge edges and read a priority-encoded vector. Read data is registered, matching the CPU's synchronous-memory `DI` timing.

## Interface

Parameters:

- `BASE`, default 16'hFE00: base address of the 4-byte register window; `AD[15:2]` must equal `BASE[15:2]`.

Ports:

- `clk`  in  1: CPU clock; all state changes on the rising edge.
- `RST`  in  1: reset, asynchronous, active-low (0 = reset).
- `AD`  in  16: CPU address bus (combinatorial from the CPU).
- `DO`  in  8: CPU write data.
- `WE`  in  1: CPU write enable.
- `RDY`  in  1: CPU ready; bus writes only take effect when `RDY`=1.
- `src`  in  8: asynchronous interrupt sources, active-high.
- `nmi_src`  in  1: asynchronous NMI source, rising-edge triggered.
- `rd_data`  out  8: registered read data, for the system `DI` mux.
- `sel`  out  1: registered flag, high when `rd_data` belongs to this block.
- `IRQ`  out  1: registered interrupt request to the CPU, active-high.
- `NMI`  out  1: registered NMI latch to the CPU, active-high.

## Operation

- **Synchroniser.** Each `src` bit and `nmi_src` passes through three flops: `s1`, `s2`, `s3`. `s2` is the synchronised level. A rising edge is `s2 & ~s3`.
- **Register map** (offset = `AD[1:0]`, hit = `AD[15:2]`==`BASE[15:2]`):
  - 0 STATUS: read returns `pending[7:0]`. Writing 1 to a bit clears it, edge-mode bits only.
  - 1 MASK: read/write. 1 = source enabled.
  - 2 MODE: read/write. 1 = edge, 0 = level.
  - 3 VECTOR: read returns `{nmi_lat, any, 3'b000, idx[2:0]}`. `any` = |(pending & MASK). `idx` = lowest-numbered bit set in (pending & MASK), 0 when `any`=0. Writing with `DO[7]`=1 clears `nmi_lat`; other bits are ignored.
- **Write strobe.** `wr` = hit & `WE` & `RDY`, applied at the rising edge.
- **Level-mode bit.** `pending[i] <= s2[i]` every cycle. Writes to STATUS have no effect on it.
- **Edge-mode bit.** `pending[i]` is set on a rising edge and cleared by a STATUS write-1. Set and clear in the same cycle: set wins.
- **Mode change.** Changing a MODE bit does not by itself alter that pending bit. A held-high source switched from level to edge stays pending until cleared.
- **Interrupt outputs.**
  - `IRQ <= |(pending & MASK)`, using the pending values that result from the same edge's update (next-state).
  - `NMI` = `nmi_lat`. It is set on a rising edge of the synchronised `nmi_src` and cleared by a VECTOR write with `DO[7]`=1. Set wins over clear.
- **Reads.** Every cycle, `rd_data <= hit ? reg[AD[1:0]] : 8'h00` and `sel <= hit`. Reads have no side effects.
- **Reset values.** All flops reset to 0: synchronisers, `pending`, MASK, MODE, `nmi_lat`, `IRQ`, `NMI`, `rd_data`, `sel`. Reset asserted mid-operation clears everything immediately; a pending interrupt is lost.

## Timing

- **Read latency.** Address presented in cycle n → `rd_data`/`sel` valid after edge n, i.e. during cycle n+1.
- **Write latency.** A write during cycle n changes the register at edge n. A read addressed in cycle n+1 returns the new value.
- **Interrupt latency.** `src[i]` first sampled high at edge k:
  - `s2` high after k+1.
  - `pending[i]` set at edge k+2.
  - `IRQ` high after edge k+2, provided MASK[i]=1.
  - NMI follows the same timing.
- **Deassertion.**
  - Edge mode: `IRQ` falls after the edge that applies the clearing write.
  - Level mode: `IRQ` falls after edge j+2, where j is the first edge sampling `src[i]` low.
- **Pulse width.** A `src` pulse shorter than one `clk` period may be missed; sources must hold for at least one full cycle.
- **`RDY`=0.** Writes are suppressed. Reads, synchronisers and interrupt logic keep running.

## Test plan

- **Reset.** Assert `RST`=0 with random inputs → all outputs 0. Release, read offsets 0–3 → `rd_data` 00, 00, 00, 00; `sel`=1 only on hit cycles.
- **Edge mode.** Write MASK=8'h04, MODE=8'h04; pulse `src[2]` for 2 cycles → `IRQ`=1 exactly 3 edges after the first sampling edge. VECTOR reads 8'h42. Write STATUS=8'h04 → `IRQ`=0 next cycle, STATUS reads 00.
- **Level mode and priority.** MODE=00, MASK=8'hFF, hold `src`=8'h28 → VECTOR reads 8'h43. Drop `src[3]` → VECTOR reads 8'h45. Drop `src[5]` → `IRQ`=0 and VECTOR reads 00.
- **Set beats clear.** Rising edge of `src[1]` (edge mode) lands on the same edge as a STATUS write of 8'h02 → `pending[1]` stays 1 and `IRQ` stays 1.
- **NMI.** Rising `nmi_src` → `NMI`=1 after 3 edges; VECTOR bit 7 = 1. Writing VECTOR=8'h7F leaves `NMI`=1. Writing 8'h80 clears it. Holding `nmi_src` high does not re-set it.
- **RDY gating.** Write MASK=8'hFF with `RDY`=0 → MASK still reads 00. Repeat with `RDY`=1 → reads FF.

Source files
------------

// File: rtl/irq_ctl.sv
// Interrupt controller for the 65C02: synchronises 8 IRQ sources and one NMI,
// holds pending/mask/mode registers in a 4-byte bus window, drives IRQ and NMI.
module irq_ctl #(
  parameter logic [15:0] BASE = 16'hFE00
) (
  input  logic        clk,
  input  logic        RST,
  input  logic [15:0] AD,
  input  logic [7:0]  DO,
  input  logic        WE,
  input  logic        RDY,
  input  logic [7:0]  src,
  input  logic        nmi_src,
  output logic [7:0]  rd_data,
  output logic        sel,
  output logic        IRQ,
  output logic        NMI
);

  typedef enum logic [1:0] {
    REG_STATUS = 2'd0,
    REG_MASK   = 2'd1,
    REG_MODE   = 2'd2,
    REG_VECTOR = 2'd3
  } reg_e;

  // Bit 8 of each synchroniser stage carries nmi_src.
  logic [8:0] s1, s2, s3;
  logic [8:0] rise;
  logic [7:0] pending, mask, mode;
  logic       nmi_lat;

  logic       hit, wr;
  reg_e       off;
  logic [7:0] clr, pend_next, active;
  logic       nmi_next, irq_next, any;
  logic [2:0] idx;
  logic [7:0] rd_mux;

  assign hit  = (AD[15:2] == BASE[15:2]);
  assign wr   = hit & WE & RDY;
  assign off  = reg_e'(AD[1:0]);
  assign rise = s2 & ~s3;
  assign NMI  = nmi_lat;

  always_comb begin
    clr = '0;
    if (wr && off == REG_STATUS) clr = DO;
    // Edge bits: set has priority over a same-cycle write-1 clear.
    // Level bits simply follow the synchronised source.
    pend_next = (mode & ((pending & ~clr) | rise[7:0])) | (~mode & s2[7:0]);
    irq_next  = |(pend_next & mask);
    nmi_next  = rise[8] | (nmi_lat & ~(wr && off == REG_VECTOR && DO[7]));
  end

  always_comb begin
    active = pending & mask;
    any    = |active;
    idx    = '0;
    // Scan downwards so the lowest-numbered active source is the last to win.
    for (int unsigned i = 8; i > 0; i--) begin
      if (active[i-1]) idx = 3'(i - 1);
    end
  end

  always_comb begin
    rd_mux = '0;
    case (off)
      REG_STATUS: rd_mux = pending;
      REG_MASK:   rd_mux = mask;
      REG_MODE:   rd_mux = mode;
      REG_VECTOR: rd_mux = {nmi_lat, any, 3'b000, idx};
      default:    rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      s1      <= '0;
      s2      <= '0;
      s3      <= '0;
      pending <= '0;
      mask    <= '0;
      mode    <= '0;
      nmi_lat <= 1'b0;
      IRQ     <= 1'b0;
      rd_data <= '0;
      sel     <= 1'b0;
    end else begin
      s1      <= {nmi_src, src};
      s2      <= s1;
      s3      <= s2;
      pending <= pend_next;
      nmi_lat <= nmi_next;
      IRQ     <= irq_next;
      if (wr && off == REG_MASK) mask <= DO;
      if (wr && off == REG_MODE) mode <= DO;
      rd_data <= hit ? rd_mux : '0;
      sel     <= hit;
    end
  end

endmodule
